// File: rtl/zbt_pkg.sv
// Shared ZBT definitions: bus geometry, command encoding and the
// read/write latency rule, used by the responder and the controller side.
package zbt_pkg;

    localparam int DSIZE  = 36;
    localparam int BWSIZE = 4;

    function automatic int lane_width(input int dsize, input int bwsize);
        return dsize / bwsize;
    endfunction

    localparam int LANE_W = lane_width(DSIZE, BWSIZE);

    // Edges between command acceptance and data on the bus.
    function automatic int latency(input int flowthrough);
        return 2 - flowthrough;
    endfunction

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

endpackage

// File: rtl/zbt_bw_ram.sv
// Byte-lane word array: synchronous write with per-lane enables,
// combinational read so the caller controls read timing.
module zbt_bw_ram
    import zbt_pkg::*;
#(
    parameter int DSIZE  = zbt_pkg::DSIZE,
    parameter int BWSIZE = zbt_pkg::BWSIZE,
    parameter int ASIZE  = 8
) (
    input  logic              clk,
    input  logic [BWSIZE-1:0] we,
    input  logic [ASIZE-1:0]  waddr,
    input  logic [DSIZE-1:0]  wdata,
    input  logic [ASIZE-1:0]  raddr,
    output logic [DSIZE-1:0]  rdata
);

    localparam int LW = lane_width(DSIZE, BWSIZE);

    logic [DSIZE-1:0] mem [2**ASIZE];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BWSIZE; i++) begin
            if (we[i]) mem[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/zbt_sram_responder.sv
// ZBT SRAM responder: commands ride a LAT-deep slot pipeline, and the
// slot at its tail either captures write data or loads read data.
module zbt_sram_responder
    import zbt_pkg::*;
#(
    parameter int FLOWTHROUGH = 0,
    parameter int DSIZE       = zbt_pkg::DSIZE,
    parameter int BWSIZE      = zbt_pkg::BWSIZE,
    parameter int ASIZE       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_n,
    input  logic              rw_n,
    input  logic [ASIZE-1:0]  addr,
    input  logic [BWSIZE-1:0] bw_n,
    input  logic [DSIZE-1:0]  data_in,
    output logic [DSIZE-1:0]  data_out,
    output logic              data_out_en
);

    localparam int LAT = latency(FLOWTHROUGH);

    typedef struct packed {
        logic              vld;
        op_e               op;
        logic [ASIZE-1:0]  addr;
        logic [BWSIZE-1:0] bw_n;
    } cmd_t;

    cmd_t              cmd_in;
    cmd_t              tail;
    cmd_t              pipe [1:LAT];
    logic              wr_go;
    logic              rd_go;
    logic [BWSIZE-1:0] lane_we;
    logic [DSIZE-1:0]  rdata;

    always_comb begin
        cmd_in      = '0;
        cmd_in.vld  = ~ce_n;
        cmd_in.op   = op_e'(rw_n);
        cmd_in.addr = addr;
        cmd_in.bw_n = bw_n;
    end

    // Async clear drops in-flight commands before their data edge arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[1] <= cmd_in;
            for (int i = 2; i <= LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail    = pipe[LAT];
    assign wr_go   = tail.vld && (tail.op == OP_WRITE);
    assign rd_go   = tail.vld && (tail.op == OP_READ);
    assign lane_we = wr_go ? ~tail.bw_n : '0;

    zbt_bw_ram #(
        .DSIZE (DSIZE),
        .BWSIZE(BWSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk  (clk),
        .we   (lane_we),
        .waddr(tail.addr),
        .wdata(data_in),
        .raddr(tail.addr),
        .rdata(rdata)
    );

    // The array read sees every write that landed on earlier edges,
    // which covers a write accepted one edge before this read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            data_out_en <= 1'b0;
        end else begin
            data_out_en <= rd_go;
            if (rd_go) data_out <= rdata;
        end
    end

endmodule
